// File: rtl/multi_seq_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_seq_detector_pkg
// Description : Shared types and helpers for the multi-pattern serial
//               sequence detector: derived width helpers, the length-to-mask
//               function and the per-slot configuration record.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_seq_detector_pkg;

    // Widest pattern / length field any instance can be built with. The
    // config record is sized to these so one type serves every parameter set.
    localparam int C_MAX_PAT_W = 32;
    localparam int C_MAX_LEN_W = 6;

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int calc_idx_w(input int n_pat);
        return (n_pat > 1) ? $clog2(n_pat) : 1;
    endfunction

    // Low `len` bits set; len >= 32 yields all ones.
    function automatic logic [C_MAX_PAT_W-1:0] len_mask(input logic [C_MAX_LEN_W-1:0] len);
        if (len >= C_MAX_LEN_W'(C_MAX_PAT_W)) begin
            return '1;
        end
        return (C_MAX_PAT_W'(1) << len) - C_MAX_PAT_W'(1);
    endfunction

    typedef struct packed {
        logic [C_MAX_PAT_W-1:0] pat;
        logic [C_MAX_LEN_W-1:0] len;
        logic                   ovl;
    } slot_cfg_t;

endpackage : multi_seq_detector_pkg
`default_nettype wire

// File: rtl/multi_seq_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_seq_detector_if
// Description : Stream, configuration and result bundle of the detector.
//               master : drives stream/config, observes results
//               slave  : the detector itself
//   x_valid/x            serial stream bit and its qualifier
//   cfg_we/idx/pat/len/ovl  slot configuration write
//   cnt_clr              clear all hit counters
//   match/match_any/match_id/hit_cnt  registered results
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_seq_detector_if
    import multi_seq_detector_pkg::*;
#(
    parameter int N_PAT   = 4,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = calc_len_w(MAX_LEN);
    localparam int IDX_W = calc_idx_w(N_PAT);

    logic                   x_valid;
    logic                   x;
    logic                   cfg_we;
    logic [IDX_W-1:0]       cfg_idx;
    logic [MAX_LEN-1:0]     cfg_pat;
    logic [LEN_W-1:0]       cfg_len;
    logic                   cfg_ovl;
    logic                   cnt_clr;
    logic [N_PAT-1:0]       match;
    logic                   match_any;
    logic [IDX_W-1:0]       match_id;
    logic [N_PAT*CNT_W-1:0] hit_cnt;

    modport master (
        output x_valid, x, cfg_we, cfg_idx, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        input  match, match_any, match_id, hit_cnt
    );

    modport slave (
        input  x_valid, x, cfg_we, cfg_idx, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        output match, match_any, match_id, hit_cnt
    );

endinterface : multi_seq_detector_if
`default_nettype wire

// File: rtl/multi_seq_detector_slot.sv
`default_nettype none
// ============================================================================
// Module      : seq_pat_slot
// Description : One pattern slot. Holds its configuration, a fill counter of
//               stream bits accepted since the last restart, and a saturating
//               hit counter. Produces a combinational hit for the top to
//               register.
//   i_x_valid   stream bit present this cycle
//   i_hist_nx   history including this cycle's bit (bit 0 = newest)
//   i_cfg_load  load i_cfg into this slot (restarts fill, clears counter)
//   i_cnt_clr   clear hit counter
//   o_hit       pattern completes on this cycle's bit
//   o_hit_cnt   saturating hit count
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pat_slot
    import multi_seq_detector_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               i_x_valid,
    input  wire logic [MAX_LEN-1:0] i_hist_nx,
    input  wire logic               i_cfg_load,
    input  wire slot_cfg_t          i_cfg,
    input  wire logic               i_cnt_clr,
    output logic                    o_hit,
    output logic [CNT_W-1:0]        o_hit_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    slot_cfg_t              r_cfg_q, w_cfg_d;
    logic [C_MAX_LEN_W-1:0] r_fill_q, w_fill_d, w_fill_nx;
    logic [CNT_W-1:0]       r_cnt_q, w_cnt_d;
    logic [C_MAX_PAT_W-1:0] w_hist_ext, w_diff;

    always_comb begin
        // Compare at full record width; the mask clears everything above len,
        // and len never exceeds MAX_LEN, so the zero-extended history is exact.
        w_hist_ext = C_MAX_PAT_W'(i_hist_nx);
        w_diff     = (w_hist_ext ^ r_cfg_q.pat) & len_mask(r_cfg_q.len);
        w_fill_nx  = (r_fill_q < r_cfg_q.len) ? r_fill_q + 1'b1 : r_cfg_q.len;

        // A slot being rewritten this cycle starts over and cannot hit.
        o_hit = i_x_valid && !i_cfg_load && (r_cfg_q.len != '0) &&
                (w_fill_nx == r_cfg_q.len) && (w_diff == '0);

        w_cfg_d  = r_cfg_q;
        w_fill_d = r_fill_q;
        w_cnt_d  = r_cnt_q;

        if (i_cfg_load) begin
            w_cfg_d  = i_cfg;
            w_fill_d = '0;
            w_cnt_d  = '0;
        end else begin
            if (i_x_valid) begin
                // Non-overlapping mode discards every bit consumed by the hit.
                w_fill_d = (o_hit && !r_cfg_q.ovl) ? '0 : w_fill_nx;
            end
            if (i_cnt_clr) begin
                w_cnt_d = '0;
            end else if (o_hit && (r_cnt_q != C_CNT_MAX)) begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_q  <= '0;
            r_fill_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            r_cfg_q  <= w_cfg_d;
            r_fill_q <= w_fill_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

    assign o_hit_cnt = r_cnt_q;

endmodule : seq_pat_slot
`default_nettype wire

// File: rtl/multi_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : multi_seq_detector
// Description : Serial bit-stream detector with N_PAT run-time programmable
//               patterns (up to MAX_LEN bits each, per-slot overlap mode and
//               saturating hit counter). All results are registered.
//   clk, reset  clock and synchronous active-high reset
//   bus         multi_seq_detector_if.slave (stream, config, results)
// Revision    : 1.0 - initial release
// ============================================================================
module multi_seq_detector
    import multi_seq_detector_pkg::*;
#(
    parameter int N_PAT   = 4,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    multi_seq_detector_if.slave   bus
);

    localparam int LEN_W = calc_len_w(MAX_LEN);
    localparam int IDX_W = calc_idx_w(N_PAT);

    // Only MAX_LEN-1 past bits are stored: together with the incoming bit
    // they form the full MAX_LEN-bit window the slots compare against.
    logic [MAX_LEN-2:0] r_hist_q;
    logic [MAX_LEN-1:0] w_hist_d;

    logic               w_cfg_ok;
    slot_cfg_t          w_cfg_new;
    logic [N_PAT-1:0]   w_load;
    logic [N_PAT-1:0]   w_match_d, r_match_q;
    logic               r_match_any_q;
    logic [IDX_W-1:0]   w_match_id_d, r_match_id_q;
    logic [CNT_W-1:0]   w_cnt [N_PAT];

    always_comb begin
        w_hist_d = bus.x_valid ? {r_hist_q, bus.x} : {1'b0, r_hist_q};

        w_cfg_ok = bus.cfg_we && (int'(bus.cfg_idx) < N_PAT) &&
                   (int'(bus.cfg_len) <= MAX_LEN);

        w_cfg_new     = '0;
        w_cfg_new.pat = C_MAX_PAT_W'(bus.cfg_pat);
        w_cfg_new.len = C_MAX_LEN_W'(bus.cfg_len);
        w_cfg_new.ovl = bus.cfg_ovl;

        w_load = '0;
        for (int i = 0; i < N_PAT; i++) begin
            if (w_cfg_ok && (int'(bus.cfg_idx) == i)) begin
                w_load[i] = 1'b1;
            end
        end

        // Scan downward so the lowest-index hit is the last to write.
        w_match_id_d = '0;
        for (int i = N_PAT - 1; i >= 0; i--) begin
            if (w_match_d[i]) begin
                w_match_id_d = IDX_W'(i);
            end
        end
    end

    generate
        for (genvar i = 0; i < N_PAT; i++) begin : g_slot
            seq_pat_slot #(
                .MAX_LEN (MAX_LEN),
                .CNT_W   (CNT_W)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .i_x_valid  (bus.x_valid),
                .i_hist_nx  (w_hist_d),
                .i_cfg_load (w_load[i]),
                .i_cfg      (w_cfg_new),
                .i_cnt_clr  (bus.cnt_clr),
                .o_hit      (w_match_d[i]),
                .o_hit_cnt  (w_cnt[i])
            );
            assign bus.hit_cnt[i*CNT_W +: CNT_W] = w_cnt[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist_q      <= '0;
            r_match_q     <= '0;
            r_match_any_q <= 1'b0;
            r_match_id_q  <= '0;
        end else begin
            r_hist_q      <= w_hist_d[MAX_LEN-2:0];
            r_match_q     <= w_match_d;
            r_match_any_q <= |w_match_d;
            r_match_id_q  <= w_match_id_d;
        end
    end

    assign bus.match     = r_match_q;
    assign bus.match_any = r_match_any_q;
    assign bus.match_id  = r_match_id_q;

endmodule : multi_seq_detector
`default_nettype wire
